key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Front-end for the two push-buttons that drive the IIC controller.
- Synchronises the raw active-low key_rd / key_wr pins and debounces each one independently.
- Emits one single-cycle command pulse per confirmed press, which feeds the controller's read and write request inputs.
- Guarantees that read and write pulses are never asserted in the same cycle, so the controller sees at most one request per clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronised samples required to confirm a press or a release (20 ms at 50 MHz). Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-key counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- key_rd  input  1  raw read button, active-low, asynchronous to clk
- key_wr  input  1  raw write button, active-low, asynchronous to clk
- rd_pulse  output  1  one-cycle read request on a confirmed read press
- wr_pulse  output  1  one-cycle write request on a confirmed write press
- rd_held  output  1  debounced read key level, 1 = pressed
- wr_held  output  1  debounced write key level, 1 = pressed

Behaviour:
- Reset: one clock domain (clk); reset is synchronous and active-high (rst). While rst is sampled high at a clk edge, the following values load:
  - both synchroniser stages = 1
  - both FSMs = IDLE, both counters = 0, rd_pending = 0
  - rd_pulse = wr_pulse = rd_held = wr_held = 0
- Synchroniser: 2-flop synchroniser per key. Only the second-stage output s is used downstream.
- Per-key FSM. All transitions are registered, and the counter counts only in the two CNT states.
  - IDLE: if s = 0, go to PRESS_CNT with cnt = 0; otherwise stay.
  - PRESS_CNT: if s = 1, go to IDLE with cnt = 0 (glitch rejected).
    - Else if cnt == DEBOUNCE_CYCLES-1, go to PRESSED and raise the confirm strobe for one cycle.
    - Else cnt += 1.
  - PRESSED: if s = 1, go to RELEASE_CNT with cnt = 0; otherwise stay.
  - RELEASE_CNT: if s = 0, go to PRESSED with cnt = 0 and no new pulse.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to IDLE.
    - Else cnt += 1.
- Held outputs: held = 1 in PRESSED and RELEASE_CNT, 0 otherwise. Releases never produce a pulse.
- Latency: a key first sampled low at edge E0 and held low produces a pulse and held = 1 in the cycle after edge E(DEBOUNCE_CYCLES+2). A release is symmetric: held drops after edge E(DEBOUNCE_CYCLES+2), counted from the first high sample.
- Pulse outputs are registered and exactly one cycle wide.
  - Write confirm → wr_pulse in that cycle.
  - Read confirm with no write confirm in the same cycle → rd_pulse in that cycle.
- Collision: if read and write confirm in the same cycle, wr_pulse = 1, rd_pulse = 0 and rd_pending is set. On the next edge rd_pulse = 1 and rd_pending clears.
  - A new write confirm cannot occur in that next cycle, because the write FSM has only just entered PRESSED.
- Invariant: rd_pulse & wr_pulse == 0 in every cycle.
- A key held continuously gives exactly one pulse. A re-press needs a full confirmed release first.
- Reset mid-operation: state is discarded immediately, including any pending read.
  - A key still held low when rst deasserts must be re-confirmed. It pulses DEBOUNCE_CYCLES+2 cycles after the first sample following reset.
- Counters never wrap: the maximum count value is DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES = 4):
- Idle and reset: assert rst for 3 cycles with keys = 1, then release and run 50 cycles → all four outputs stay 0.
- Clean write press: key_wr low from edge E0 for 30 cycles, then high.
  - wr_pulse is 1 for exactly one cycle, after E6; wr_held = 1 from that cycle.
  - After release, wr_held falls 6 cycles after the first high sample.
  - No second pulse, and rd outputs stay 0 throughout.
- Press bounce: key_rd pattern low 3, high 1, low 2, high 1, then low held.
  - No pulse during the bounce.
  - rd_pulse appears once, 6 cycles after the start of the final low run.
- Release bounce: after rd_held = 1, key_rd pattern high 2, low 1, then high held.
  - rd_held stays 1 through the glitch and falls 6 cycles after the final high run begins.
  - No rd_pulse on release.
- Simultaneous press: key_rd and key_wr low on the same edge E0 → wr_pulse after E6, rd_pulse after E7, never both high together.
- Reset mid-count: key_wr low, with rst pulsed for 1 cycle at E3 while the key stays low.
  - No pulse near E6.
  - wr_pulse occurs once, 6 cycles after the first post-reset sample.

Source files
------------

// File: rtl/key_debounce.sv
// Two-key debounce front end for the IIC controller's read/write request inputs.
// Each raw active-low key is synchronised and debounced on its own. A confirmed
// press becomes a one-cycle request pulse. If both keys confirm in the same
// cycle, the write pulse goes first and the read pulse follows one cycle later,
// so the two pulses are never high together.

// Per-key debounce FSM. It acts on the synchronised key level (key_s, 0 = pressed).
//   state       | meaning
//   IDLE        | key released, waiting for a low sample
//   PRESS_CNT   | key low, counting consecutive low samples
//   PRESSED     | press confirmed, waiting for a high sample
//   RELEASE_CNT | key high, counting consecutive high samples
module key_debounce_fsm #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_s,
    output logic held,
    output logic confirm
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CNT   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CNT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // State and stability counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter update; the counter only advances in the CNT states
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_CNT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CNT: begin
                if (key_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_nxt = RELEASE_CNT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_CNT: begin
                if (!key_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Debounced level and one-cycle press-confirm strobe (asserted on the PRESSED entry edge)
    always_comb begin
        held    = (state == PRESSED) || (state == RELEASE_CNT);
        confirm = (state == PRESS_CNT) && !key_s && (cnt == CNT_MAX);
    end

endmodule

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_rd,
    input  logic key_wr,
    output logic rd_pulse,
    output logic wr_pulse,
    output logic rd_held,
    output logic wr_held
);

    logic [1:0] rd_sync;
    logic [1:0] wr_sync;
    logic       rd_confirm;
    logic       wr_confirm;
    logic       rd_pending;

    // Two-flop synchronisers; they reset to the released (high) level
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sync <= 2'b11;
            wr_sync <= 2'b11;
        end else begin
            rd_sync <= {rd_sync[0], key_rd};
            wr_sync <= {wr_sync[0], key_wr};
        end
    end

    key_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_rd_fsm (
        .clk    (clk),
        .rst    (rst),
        .key_s  (rd_sync[1]),
        .held   (rd_held),
        .confirm(rd_confirm)
    );

    key_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wr_fsm (
        .clk    (clk),
        .rst    (rst),
        .key_s  (wr_sync[1]),
        .held   (wr_held),
        .confirm(wr_confirm)
    );

    // Request pulses: write wins a same-cycle collision, and read is deferred one cycle.
    // The write FSM has only just entered PRESSED then, so it cannot confirm again next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pulse   <= 1'b0;
            wr_pulse   <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            wr_pulse   <= wr_confirm;
            rd_pulse   <= (rd_confirm && !wr_confirm) || rd_pending;
            rd_pending <= rd_confirm && wr_confirm;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES = 4. Expected pulse edges and held
// transition edges are queued as stimulus is applied. The monitor pops the queues
// whenever the DUT produces a pulse or changes a held level.
module tb_key_debounce;

    localparam int N   = 4;
    localparam int LAT = N + 2;

    logic clk = 1'b0;
    logic rst;
    logic key_rd;
    logic key_wr;
    logic rd_pulse;
    logic wr_pulse;
    logic rd_held;
    logic wr_held;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    logic rd_held_prev = 1'b0;
    logic wr_held_prev = 1'b0;

    int rd_pulse_q[$];
    int wr_pulse_q[$];
    int rd_held_q[$];
    int wr_held_q[$];

    key_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .key_rd  (key_rd),
        .key_wr  (key_wr),
        .rd_pulse(rd_pulse),
        .wr_pulse(wr_pulse),
        .rd_held (rd_held),
        .wr_held (wr_held)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k, cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive keys, then let n edges pass; the inputs change 2 time units after a posedge
    task automatic apply(input logic rd, input logic wr, input int n);
        key_rd = rd;
        key_wr = wr;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_pulse && wr_pulse) check("pulse_overlap", 1, 0);
            if (rd_pulse) begin
                if (rd_pulse_q.size() == 0) check("rd_pulse_spurious", cyc, -1);
                else check("rd_pulse_edge", cyc, rd_pulse_q.pop_front());
            end
            if (wr_pulse) begin
                if (wr_pulse_q.size() == 0) check("wr_pulse_spurious", cyc, -1);
                else check("wr_pulse_edge", cyc, wr_pulse_q.pop_front());
            end
            if (rd_held !== rd_held_prev) begin
                if (rd_held_q.size() == 0) check("rd_held_spurious", cyc, -1);
                else check("rd_held_edge", cyc, rd_held_q.pop_front());
            end
            if (wr_held !== wr_held_prev) begin
                if (wr_held_q.size() == 0) check("wr_held_spurious", cyc, -1);
                else check("wr_held_edge", cyc, wr_held_q.pop_front());
            end
        end
        rd_held_prev = rd_held;
        wr_held_prev = wr_held;
    end

    initial begin
        int e;
        rst    = 1'b1;
        key_rd = 1'b1;
        key_wr = 1'b1;

        // Idle and reset
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_rd_pulse", int'(rd_pulse), 0);
        check("rst_wr_pulse", int'(wr_pulse), 0);
        check("rst_rd_held", int'(rd_held), 0);
        check("rst_wr_held", int'(wr_held), 0);
        mon_en = 1'b1;
        apply(1, 1, 50);
        check("idle_rd_pulse", int'(rd_pulse), 0);
        check("idle_wr_pulse", int'(wr_pulse), 0);
        check("idle_rd_held", int'(rd_held), 0);
        check("idle_wr_held", int'(wr_held), 0);

        // Clean write press, then release
        e = cyc + 1;
        wr_pulse_q.push_back(e + LAT);
        wr_held_q.push_back(e + LAT);
        apply(1, 0, 30);
        e = cyc + 1;
        wr_held_q.push_back(e + LAT);
        apply(1, 1, 20);

        // Press bounce on read: low 3, high 1, low 2, high 1, then low held
        e = cyc + 1;
        rd_pulse_q.push_back(e + 7 + LAT);
        rd_held_q.push_back(e + 7 + LAT);
        apply(0, 1, 3);
        apply(1, 1, 1);
        apply(0, 1, 2);
        apply(1, 1, 1);
        apply(0, 1, 20);

        // Release bounce on read: high 2, low 1, then high held
        e = cyc + 1;
        rd_held_q.push_back(e + 3 + LAT);
        apply(1, 1, 2);
        apply(0, 1, 1);
        apply(1, 1, 20);

        // Simultaneous press: write first, read deferred one cycle
        e = cyc + 1;
        wr_pulse_q.push_back(e + LAT);
        rd_pulse_q.push_back(e + LAT + 1);
        wr_held_q.push_back(e + LAT);
        rd_held_q.push_back(e + LAT);
        apply(0, 0, 20);
        e = cyc + 1;
        wr_held_q.push_back(e + LAT);
        rd_held_q.push_back(e + LAT);
        apply(1, 1, 20);

        // Reset mid-count: rst sampled at E3 only; re-confirm from first sample after reset (E4)
        e = cyc + 1;
        wr_pulse_q.push_back(e + 4 + LAT);
        wr_held_q.push_back(e + 4 + LAT);
        apply(1, 0, 3);
        rst = 1'b1;
        apply(1, 0, 1);
        rst = 1'b0;
        apply(1, 0, 20);
        e = cyc + 1;
        wr_held_q.push_back(e + LAT);
        apply(1, 1, 20);

        check("rd_pulse_q_left", rd_pulse_q.size(), 0);
        check("wr_pulse_q_left", wr_pulse_q.size(), 0);
        check("rd_held_q_left", rd_held_q.size(), 0);
        check("wr_held_q_left", wr_held_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
